// File: rtl/id_ex_stage.sv
// ID->EX pipeline register: operand selection with bypass merge, hazard
// interlock, back-pressure hold, flush bubble and a saturating bubble counter.

package common_pkg;

  typedef struct packed {
    logic [4:0] write_back_id;
    logic       reg_write;
    logic       mem_read;
  } control_t;

endpackage

module id_ex_stage
  import common_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        id_valid,
  input  logic [31:0] id_pc,
  input  logic [31:0] id_imm,
  input  logic [4:0]  id_rs_1,
  input  logic [4:0]  id_rs_2,
  input  logic        id_uses_rs_1,
  input  logic        id_uses_rs_2,
  input  control_t    id_control,
  input  logic [31:0] rf_data_1,
  input  logic [31:0] rf_data_2,
  input  logic [31:0] fwd_data_1,
  input  logic [31:0] fwd_data_2,
  input  logic        fwd_data_1_valid,
  input  logic        fwd_data_2_valid,
  input  control_t    control_mem,
  input  logic        flush,
  input  logic        ex_ready,
  output logic        ex_valid,
  output logic [31:0] ex_pc,
  output logic [31:0] ex_imm,
  output logic [31:0] ex_operand_1,
  output logic [31:0] ex_operand_2,
  output logic [4:0]  ex_rs_1,
  output logic [4:0]  ex_rs_2,
  output control_t    ex_control,
  output logic        stall_id,
  output logic [15:0] bubble_count
);

  localparam int unsigned DATA_W = 32;
  localparam int unsigned REG_W  = 5;
  localparam int unsigned CNT_W  = 16;

  logic [DATA_W-1:0] operand_1;
  logic [DATA_W-1:0] operand_2;
  logic              haz_ex_1;
  logic              haz_ex_2;
  logic              haz_ld_1;
  logic              haz_ld_2;
  logic              hazard;
  logic              ex_writes;
  logic              mem_loads;

  // Operand select: x0 always reads zero, otherwise bypass wins over the RF
  always_comb begin
    operand_1 = '0;
    operand_2 = '0;
    if (id_rs_1 != REG_W'(0)) begin
      operand_1 = fwd_data_1_valid ? fwd_data_1 : rf_data_1;
    end
    if (id_rs_2 != REG_W'(0)) begin
      operand_2 = fwd_data_2_valid ? fwd_data_2 : rf_data_2;
    end
  end

  // Interlock: producer still in EX, or a load still in MEM, blocks decode
  always_comb begin
    ex_writes = ex_valid && ex_control.reg_write &&
                (ex_control.write_back_id != REG_W'(0));
    mem_loads = control_mem.reg_write && control_mem.mem_read &&
                (control_mem.write_back_id != REG_W'(0));
    haz_ex_1  = ex_writes && (ex_control.write_back_id == id_rs_1) && id_uses_rs_1;
    haz_ex_2  = ex_writes && (ex_control.write_back_id == id_rs_2) && id_uses_rs_2;
    haz_ld_1  = mem_loads && (control_mem.write_back_id == id_rs_1) && id_uses_rs_1;
    haz_ld_2  = mem_loads && (control_mem.write_back_id == id_rs_2) && id_uses_rs_2;
    hazard    = id_valid && (haz_ex_1 || haz_ex_2 || haz_ld_1 || haz_ld_2);
    stall_id  = rst || hazard || !ex_ready;
  end

  // EX register: reset, hold on back-pressure, bubble, or accept
  always_ff @(posedge clk) begin
    if (rst) begin
      ex_valid     <= 1'b0;
      ex_pc        <= '0;
      ex_imm       <= '0;
      ex_operand_1 <= '0;
      ex_operand_2 <= '0;
      ex_rs_1      <= '0;
      ex_rs_2      <= '0;
      ex_control   <= '0;
    end else if (ex_ready) begin
      if (flush || !id_valid || hazard) begin
        ex_valid     <= 1'b0;
        ex_pc        <= '0;
        ex_imm       <= '0;
        ex_operand_1 <= '0;
        ex_operand_2 <= '0;
        ex_rs_1      <= '0;
        ex_rs_2      <= '0;
        ex_control   <= '0;
      end else begin
        ex_valid     <= 1'b1;
        ex_pc        <= id_pc;
        ex_imm       <= id_imm;
        ex_operand_1 <= operand_1;
        ex_operand_2 <= operand_2;
        ex_rs_1      <= id_rs_1;
        ex_rs_2      <= id_rs_2;
        ex_control   <= id_control;
      end
    end
  end

  // Bubble counter: one per hazard cycle that actually inserts a bubble
  always_ff @(posedge clk) begin
    if (rst) begin
      bubble_count <= '0;
    end else if (ex_ready && hazard && !flush && (bubble_count != {CNT_W{1'b1}})) begin
      bubble_count <= bubble_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: directed scenarios plus random traffic
// compared against a cycle-level behavioural model of the ID/EX boundary.

module tb_id_ex_stage;
  import common_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        id_valid;
  logic [31:0] id_pc;
  logic [31:0] id_imm;
  logic [4:0]  id_rs_1;
  logic [4:0]  id_rs_2;
  logic        id_uses_rs_1;
  logic        id_uses_rs_2;
  control_t    id_control;
  logic [31:0] rf_data_1;
  logic [31:0] rf_data_2;
  logic [31:0] fwd_data_1;
  logic [31:0] fwd_data_2;
  logic        fwd_data_1_valid;
  logic        fwd_data_2_valid;
  control_t    control_mem;
  logic        flush;
  logic        ex_ready;
  logic        ex_valid;
  logic [31:0] ex_pc;
  logic [31:0] ex_imm;
  logic [31:0] ex_operand_1;
  logic [31:0] ex_operand_2;
  logic [4:0]  ex_rs_1;
  logic [4:0]  ex_rs_2;
  control_t    ex_control;
  logic        stall_id;
  logic [15:0] bubble_count;

  id_ex_stage dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_pc(id_pc), .id_imm(id_imm),
    .id_rs_1(id_rs_1), .id_rs_2(id_rs_2),
    .id_uses_rs_1(id_uses_rs_1), .id_uses_rs_2(id_uses_rs_2),
    .id_control(id_control), .rf_data_1(rf_data_1), .rf_data_2(rf_data_2),
    .fwd_data_1(fwd_data_1), .fwd_data_2(fwd_data_2),
    .fwd_data_1_valid(fwd_data_1_valid), .fwd_data_2_valid(fwd_data_2_valid),
    .control_mem(control_mem), .flush(flush), .ex_ready(ex_ready),
    .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_imm(ex_imm),
    .ex_operand_1(ex_operand_1), .ex_operand_2(ex_operand_2),
    .ex_rs_1(ex_rs_1), .ex_rs_2(ex_rs_2), .ex_control(ex_control),
    .stall_id(stall_id), .bubble_count(bubble_count)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Reference view of what the EX stage should hold
  typedef struct {
    bit          valid;
    logic [31:0] pc;
    logic [31:0] imm;
    logic [31:0] op1;
    logic [31:0] op2;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    control_t    ctl;
  } ex_slot_t;

  ex_slot_t m_ex;
  int       m_cnt;
  bit       auto_mem;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] pick(input logic [4:0] rs, input logic fv,
                                       input logic [31:0] fd, input logic [31:0] rf);
    if (rs == 5'd0) return 32'd0;
    return fv ? fd : rf;
  endfunction

  // Does the decode instruction need a value that forwarding cannot yet supply?
  function automatic bit blocked(input logic [4:0] rs, input logic uses);
    bit from_ex;
    bit from_ld;
    from_ex = m_ex.valid && m_ex.ctl.reg_write && m_ex.ctl.write_back_id != 0 &&
              m_ex.ctl.write_back_id == rs;
    from_ld = control_mem.reg_write && control_mem.mem_read &&
              control_mem.write_back_id != 0 && control_mem.write_back_id == rs;
    return uses && (from_ex || from_ld);
  endfunction

  function automatic ex_slot_t empty_slot();
    ex_slot_t s;
    s.valid = 0; s.pc = 0; s.imm = 0; s.op1 = 0; s.op2 = 0;
    s.rs1 = 0; s.rs2 = 0; s.ctl = '0;
    return s;
  endfunction

  // One clock: check the interlock before the edge, advance the model, check after
  task automatic cycle();
    bit       haz;
    control_t next_mem;
    #1;
    haz = id_valid && (blocked(id_rs_1, id_uses_rs_1) || blocked(id_rs_2, id_uses_rs_2));
    check("stall_id", stall_id, rst || haz || !ex_ready);
    next_mem = control_mem;
    if (rst) begin
      m_ex     = empty_slot();
      m_cnt    = 0;
      next_mem = '0;
    end else if (ex_ready) begin
      next_mem = m_ex.valid ? m_ex.ctl : control_t'('0);
      if (haz && !flush && m_cnt < 16'hFFFF) m_cnt++;
      if (flush || !id_valid || haz) begin
        m_ex = empty_slot();
      end else begin
        m_ex.valid = 1;
        m_ex.pc    = id_pc;
        m_ex.imm   = id_imm;
        m_ex.op1   = pick(id_rs_1, fwd_data_1_valid, fwd_data_1, rf_data_1);
        m_ex.op2   = pick(id_rs_2, fwd_data_2_valid, fwd_data_2, rf_data_2);
        m_ex.rs1   = id_rs_1;
        m_ex.rs2   = id_rs_2;
        m_ex.ctl   = id_control;
      end
    end
    @(posedge clk);
    #1;
    if (auto_mem) control_mem = next_mem;
    check("ex_valid", ex_valid, m_ex.valid);
    check("ex_pc", ex_pc, m_ex.pc);
    check("ex_imm", ex_imm, m_ex.imm);
    check("ex_operand_1", ex_operand_1, m_ex.op1);
    check("ex_operand_2", ex_operand_2, m_ex.op2);
    check("ex_rs_1", ex_rs_1, m_ex.rs1);
    check("ex_rs_2", ex_rs_2, m_ex.rs2);
    check("ex_control", 64'(ex_control), 64'(m_ex.ctl));
    check("bubble_count", bubble_count, 64'(m_cnt));
  endtask

  task automatic idle_inputs();
    rst = 0; id_valid = 1; id_pc = 0; id_imm = 0;
    id_rs_1 = 0; id_rs_2 = 0; id_uses_rs_1 = 0; id_uses_rs_2 = 0;
    id_control = '0; rf_data_1 = 0; rf_data_2 = 0;
    fwd_data_1 = 0; fwd_data_2 = 0; fwd_data_1_valid = 0; fwd_data_2_valid = 0;
    flush = 0; ex_ready = 1;
  endtask

  task automatic do_reset();
    rst = 1;
    cycle();
    rst = 0;
  endtask

  initial begin
    m_ex = empty_slot();
    m_cnt = 0;
    auto_mem = 1;
    control_mem = '0;
    idle_inputs();

    // Reset for two cycles with a valid decode instruction waiting
    rst = 1; id_pc = 32'h100;
    repeat (2) begin
      #1; check("rst_stall", stall_id, 1'b1);
      cycle();
      check("rst_ex_valid", ex_valid, 1'b0);
      check("rst_bubble_count", bubble_count, 16'd0);
    end
    rst = 0;
    cycle();
    check("rel_ex_pc", ex_pc, 32'h100);
    check("rel_ex_valid", ex_valid, 1'b1);

    // Operand select: bypass beats RF, x0 beats bypass
    idle_inputs();
    id_rs_1 = 5; fwd_data_1_valid = 1; fwd_data_1 = 32'hAAAA0000; rf_data_1 = 32'h1111;
    id_rs_2 = 0; fwd_data_2_valid = 1; fwd_data_2 = 32'hFFFFFFFF; rf_data_2 = 32'h2222;
    cycle();
    check("sel_fwd", ex_operand_1, 32'hAAAA0000);
    check("sel_x0", ex_operand_2, 32'd0);

    // ALU-use: add x3 then a reader of x3
    idle_inputs();
    id_pc = 32'h200; id_control = '{write_back_id: 5'd3, reg_write: 1'b1, mem_read: 1'b0};
    cycle();
    idle_inputs();
    id_pc = 32'h204; id_rs_1 = 3; id_uses_rs_1 = 1; rf_data_1 = 32'h33;
    #1; check("alu_stall", stall_id, 1'b1);
    cycle();
    check("alu_bubble", ex_valid, 1'b0);
    check("alu_count", bubble_count, 16'd1);
    #1; check("alu_release", stall_id, 1'b0);
    cycle();
    check("alu_accept", ex_pc, 32'h204);
    check("alu_count_hold", bubble_count, 16'd1);

    // Load-use: lw x7 then a reader of x7, value arrives via forwarding
    idle_inputs();
    do_reset();
    id_pc = 32'h300; id_control = '{write_back_id: 5'd7, reg_write: 1'b1, mem_read: 1'b1};
    cycle();
    idle_inputs();
    id_pc = 32'h304; id_rs_1 = 7; id_uses_rs_1 = 1; rf_data_1 = 32'h77;
    fwd_data_1_valid = 1; fwd_data_1 = 32'hDEADBEEF;
    repeat (2) begin
      #1; check("ld_stall", stall_id, 1'b1);
      cycle();
      check("ld_bubble", ex_valid, 1'b0);
    end
    check("ld_count", bubble_count, 16'd2);
    cycle();
    check("ld_accept_pc", ex_pc, 32'h304);
    check("ld_operand", ex_operand_1, 32'hDEADBEEF);

    // Back-pressure holds EX, then a flush loads a bubble
    idle_inputs();
    id_pc = 32'h400; id_imm = 32'h44;
    cycle();
    id_pc = 32'h404; ex_ready = 0;
    repeat (3) begin
      #1; check("bp_stall", stall_id, 1'b1);
      cycle();
      check("bp_hold_pc", ex_pc, 32'h400);
      check("bp_hold_valid", ex_valid, 1'b1);
    end
    ex_ready = 1; flush = 1;
    id_control = '{write_back_id: 5'd4, reg_write: 1'b1, mem_read: 1'b0};
    cycle();
    check("flush_valid", ex_valid, 1'b0);
    check("flush_reg_write", ex_control.reg_write, 1'b0);

    // Random traffic with a narrow register range so hazards are frequent
    for (int i = 0; i < 400; i++) begin
      rst = ($urandom_range(0, 49) == 0);
      id_valid = ($urandom_range(0, 9) < 8);
      id_pc = $urandom; id_imm = $urandom;
      id_rs_1 = 5'($urandom_range(0, 3)); id_rs_2 = 5'($urandom_range(0, 3));
      id_uses_rs_1 = 1'($urandom); id_uses_rs_2 = 1'($urandom);
      id_control.write_back_id = 5'($urandom_range(0, 3));
      id_control.reg_write = 1'($urandom);
      id_control.mem_read = 1'($urandom);
      rf_data_1 = $urandom; rf_data_2 = $urandom;
      fwd_data_1 = $urandom; fwd_data_2 = $urandom;
      fwd_data_1_valid = 1'($urandom); fwd_data_2_valid = 1'($urandom);
      flush = ($urandom_range(0, 9) == 0);
      ex_ready = ($urandom_range(0, 9) < 8);
      cycle();
    end

    // Saturation: a load parked in MEM keeps the hazard alive every cycle
    idle_inputs();
    do_reset();
    auto_mem = 0;
    control_mem = '{write_back_id: 5'd1, reg_write: 1'b1, mem_read: 1'b1};
    id_rs_1 = 1; id_uses_rs_1 = 1;
    while (m_cnt < 16'hFFFE) cycle();
    check("sat_preload", bubble_count, 16'hFFFE);
    repeat (3) cycle();
    check("sat_stop", bubble_count, 16'hFFFF);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
